ifu_fetch: RTL and testbench

//  Fetch-side initiator for the word-addressed instruction ROM. Owns the PC:
//  - drives the ROM address
//  - takes back the combinational instruction word
//  - presents {pc, instr, exc} to decode via a registered valid/ready stage

---
 rtl/ifu_fetch_if.sv | 24 ++
 rtl/ifu_fetch.sv | 93 +++++++++
 tb/tb_ifu_fetch.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-side bus: instruction ROM port, decode valid/ready stage, redirect
// input and the fetch counter.
interface ifu_fetch_if;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_exc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  modport master (
    output im_addr, id_valid, id_pc, id_instr, id_exc, fetch_count,
    input  im_instr, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  im_addr, id_valid, id_pc, id_instr, id_exc, fetch_count,
    output im_instr, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, reads the ROM combinationally and
// registers {pc, instr, exc} into a valid/ready decode stage; halts on fetch faults.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic         clk,
  input  logic         reset,
  ifu_fetch_if.master  bus
);

  localparam logic [32:0] PC_LO = 33'(PC_BASE);
  localparam logic [32:0] PC_HI = 33'(PC_BASE) + 33'(IM_WORDS) * 33'd4;

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_exc_q, id_exc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic bad_c;
  logic load_c;

  // 33-bit range compare keeps the upper bound from overflowing
  assign bad_c = (pc_q[1:0] != 2'b00) |
                 ({1'b0, pc_q} < PC_LO) |
                 ({1'b0, pc_q} >= PC_HI);

  assign load_c = (state_q == RUN) & (~id_valid_q | bus.id_ready) & ~bus.redirect;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    id_exc_d      = id_exc_q;
    fetch_count_d = fetch_count_q;

    if (bus.redirect) begin
      pc_d       = bus.redirect_pc;
      id_valid_d = 1'b0;
      state_d    = RUN;
    end else if (load_c) begin
      id_pc_d       = pc_q;
      id_instr_d    = bad_c ? 32'h0 : bus.im_instr;
      id_exc_d      = bad_c;
      id_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
      if (bad_c) begin
        state_d = HALT;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else if (id_valid_q && bus.id_ready) begin
      // Only reachable in HALT: the faulting word drains without a refill
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'h0;
      id_instr_q    <= 32'h0;
      id_exc_q      <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
      id_exc_q      <= id_exc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.im_addr     = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_exc      = id_exc_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: expected decode words go into a scoreboard
// queue and a monitor compares each word as decode accepts it.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  ifu_fetch_if bus();

  exp_t sb[$];
  int   checks;
  int   failures;

  ifu_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: ROM[i] = 0x1000_0000 + i over the legal window
  always_comb begin
    if (bus.im_addr >= 32'h3000 && bus.im_addr < 32'h4000)
      bus.im_instr = 32'h1000_0000 + ((bus.im_addr - 32'h3000) >> 2);
    else
      bus.im_instr = 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                      input logic exc, input logic [31:0] cnt);
    exp_t e;
    e.pc = pc; e.instr = instr; e.exc = exc; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Sample each accepted word mid-cycle, ahead of the edge that consumes it
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual_pc=%h required=none t=%0t", bus.id_pc, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_pc",    bus.id_pc,          e.pc);
          chk("sb_instr", bus.id_instr,       e.instr);
          chk("sb_exc",   32'(bus.id_exc),    32'(e.exc));
          chk("sb_count", bus.fetch_count,    e.cnt);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    fork
      monitor();
    join_none

    #1;
    chk("rst_im_addr", bus.im_addr,           32'h3000);
    chk("rst_valid",   32'(bus.id_valid),     32'h0);
    chk("rst_pc",      bus.id_pc,             32'h0);
    chk("rst_count",   bus.fetch_count,       32'h0);

    // Sequential fetch after reset release
    tick();
    reset = 1'b0;
    push(32'h3000, 32'h1000_0000, 1'b0, 32'd1);
    push(32'h3004, 32'h1000_0001, 1'b0, 32'd2);
    push(32'h3008, 32'h1000_0002, 1'b0, 32'd3);
    tick();
    chk("first_valid", 32'(bus.id_valid), 32'h1);
    tick();
    tick();
    bus.id_ready = 1'b0;

    // Stall holds the presented word and the next pc
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pc",    bus.id_pc,         32'h3008);
      chk("stall_instr", bus.id_instr,      32'h1000_0002);
      chk("stall_addr",  bus.im_addr,       32'h300C);
      chk("stall_count", bus.fetch_count,   32'd3);
      chk("stall_valid", 32'(bus.id_valid), 32'h1);
    end
    bus.id_ready = 1'b1;
    push(32'h300C, 32'h1000_0003, 1'b0, 32'd4);
    tick();

    // Redirect to 0x3100; presented word still counts as consumed
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3100;
    tick();
    bus.redirect = 1'b0;
    chk("redir_valid", 32'(bus.id_valid), 32'h0);
    chk("redir_addr",  bus.im_addr,       32'h3100);
    chk("redir_count", bus.fetch_count,   32'd4);
    push(32'h3100, 32'h1000_0040, 1'b0, 32'd5);
    tick();
    chk("redir_load_valid", 32'(bus.id_valid), 32'h1);
    chk("redir_load_pc",    bus.id_pc,         32'h3100);

    // Misaligned redirect raises an exception and halts
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3102;
    tick();
    bus.redirect = 1'b0;
    push(32'h3102, 32'h0, 1'b1, 32'd6);
    tick();
    tick();
    chk("halt_valid", 32'(bus.id_valid), 32'h0);
    chk("halt_addr",  bus.im_addr,       32'h3102);
    chk("halt_count", bus.fetch_count,   32'd6);
    tick();
    chk("halt_hold_valid", 32'(bus.id_valid), 32'h0);
    chk("halt_hold_addr",  bus.im_addr,       32'h3102);

    // Redirect back to 0x3000 leaves HALT
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3000;
    tick();
    bus.redirect = 1'b0;
    push(32'h3000, 32'h1000_0000, 1'b0, 32'd7);
    tick();

    // Run off the end of the ROM
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3FF8;
    tick();
    bus.redirect = 1'b0;
    push(32'h3FF8, 32'h1000_03FE, 1'b0, 32'd8);
    push(32'h3FFC, 32'h1000_03FF, 1'b0, 32'd9);
    push(32'h4000, 32'h0,         1'b1, 32'd10);
    tick();
    tick();
    tick();
    tick();
    chk("runoff_valid", 32'(bus.id_valid), 32'h0);
    chk("runoff_addr",  bus.im_addr,       32'h4000);
    chk("runoff_count", bus.fetch_count,   32'd10);

    // Async reset during a stall with a word presented
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3000;
    bus.id_ready    = 1'b0;
    tick();
    bus.redirect = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(bus.id_valid), 32'h1);
    chk("pre_rst_count", bus.fetch_count,   32'd11);
    tick();
    chk("pre_rst_addr",  bus.im_addr,       32'h3004);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(bus.id_valid), 32'h0);
    chk("async_addr",  bus.im_addr,       32'h3000);
    chk("async_count", bus.fetch_count,   32'h0);
    chk("async_pc",    bus.id_pc,         32'h0);
    chk("async_instr", bus.id_instr,      32'h0);
    chk("async_exc",   32'(bus.id_exc),   32'h0);

    tick();
    reset = 1'b0;
    bus.id_ready = 1'b1;
    push(32'h3000, 32'h1000_0000, 1'b0, 32'd1);
    tick();
    @(negedge clk);
    #1;
    bus.id_ready = 1'b0;
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
